mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
Memory-access stage of the 5-stage RV32I pipeline. It sits directly downstream of the execute stage, behind the ex/mem pipeline register. It consumes the execute result, load/store opcode, effective address and store data, and performs loads/stores over a single-outstanding req/ack data bus. It forwards a registered result to the mem/wb register and stalls the pipeline while a bus transaction is in flight.

Parameters:
TIMEOUT, 16, max cycles in BUS waiting for bus_ack_i before aborting with bus_err_o
TO_W, 5, timeout counter width; must hold TIMEOUT

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
valid_i  in  1  instruction present from ex/mem register
wd_i  in  5  destination register address
wreg_i  in  1  register write enable
wdata_i  in  32  execute result (non-memory ops)
aluop_i  in  8  operation code (AluOpBus)
mem_addr_i  in  32  effective address
reg2_i  in  32  store data
wd_o  out  5  destination to mem/wb
wreg_o  out  1  write enable to mem/wb
wdata_o  out  32  writeback data
valid_o  out  1  result valid this cycle
stallreq_o  out  1  stall request to pipeline control
misalign_o  out  1  one-cycle pulse: misaligned access dropped
bus_err_o  out  1  one-cycle pulse: bus timeout
bus_req_o  out  1  bus request
bus_we_o  out  1  1 = write
bus_addr_o  out  32  word address {addr[31:2],2'b00}
bus_sel_o  out  4  byte-lane enables
bus_wdata_o  out  32  lane-replicated store data
bus_rdata_i  in  32  read data, valid with ack
bus_ack_i  in  1  transaction complete

Behaviour:
- Reset: state IDLE; all outputs 0; timeout counter 0. Reset during BUS drops bus_req_o at the same edge. No DONE and no valid_o follow.
- Memory ops: LB, LH, LW, LBU, LHU, SB, SH, SW. Codes come from the shared defines. All other ops are non-memory.
- Alignment: H ops need addr[0]=0; W ops need addr[1:0]=0. Byte ops are always aligned.
- IDLE, no valid_i: next cycle valid_o=0, wreg_o=0.
- IDLE, valid non-memory op: next cycle valid_o=1, wd/wreg/wdata passed through. 1-cycle latency, no stall.
- IDLE, valid misaligned memory op: no bus access. Next cycle valid_o=1, wreg_o=0, misalign_o=1.
- IDLE, valid aligned memory op (launch cycle):
  - stallreq_o=1 combinationally.
  - Latch the request registers.
  - Go to BUS.
- BUS:
  - bus_req_o=1 and stallreq_o=1; request fields stay stable; counter increments each cycle.
  - On bus_ack_i: latch result, go to DONE.
  - On counter reaching TIMEOUT-1 without ack: go to DONE with error flag.
- DONE (one cycle):
  - stallreq_o=0, valid_o=1.
  - Loads: wdata_o = extracted data, wreg_o = wreg_i. Stores: wreg_o=0.
  - On error: wreg_o=0, bus_err_o=1.
  - Go to IDLE unconditionally. Upstream advances at the end of DONE, so the held instruction is never re-launched.
- Minimum memory-op latency: launch → BUS (ack on first req cycle) → DONE = result 2 cycles after launch.
- Store lanes:
  - SB: sel = 4'b0001 << addr[1:0]; data = {4{rs2[7:0]}}.
  - SH: sel = addr[1] ? 1100 : 0011; data = {2{rs2[15:0]}}.
  - SW: sel = 1111; data = rs2.
- Loads:
  - Read: bus_we_o=0; sel uses the same lane rule as the matching store.
  - Byte/half selected by addr[1:0]/addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- bus_ack_i outside BUS is ignored.
- valid_i is ignored outside IDLE.
- bus_* outputs are 0 whenever not in BUS.

Decomposition:
- Shared defines hold the load/store aluop codes, RegBus/RegAddrBus/AluOpBus widths, and the state encoding localparams (IDLE, BUS, DONE).
- One natural sub-module, lsu_lane: purely combinational.
  - Store direction: sel and wdata from op, addr[1:0] and rs2.
  - Load direction: extracted, extended data from op, addr[1:0] and rdata.
- FSM, counter and output registers stay in mem_lsu.

Test Plan:
- Non-memory op, wdata_i=0x1234, wd_i=5, wreg_i=1 → next cycle valid_o=1, wdata_o=0x1234, wd_o=5, stallreq_o never 1.
- SB addr=0x1003, rs2=0x000000AB, ack on first req cycle → bus_sel_o=1000, bus_wdata_o=0xABABABAB, bus_addr_o=0x1000; DONE has wreg_o=0; total stall 2 cycles.
- LB addr=0x2001, rdata=0x00008000 → wdata_o=0xFFFFFF80. LBU same → 0x00000080. LH addr=0x2002, rdata=0x80010000 → 0xFFFF8001.
- LW addr=0x3002 → no bus_req_o; next cycle misalign_o=1, valid_o=1, wreg_o=0.
- LW, ack withheld → bus_req_o held exactly 16 cycles, then bus_err_o=1, wreg_o=0, return to IDLE.
- Reset asserted on 2nd BUS cycle → next cycle bus_req_o=0, valid_o=0, stallreq_o=0; a late ack is ignored.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the memory-access stage: bus widths, load/store
// opcodes, FSM state encoding, latched request payload and opcode helpers.
package mem_lsu_pkg;

    localparam int unsigned REG_W      = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned ALUOP_W    = 8;

    localparam logic [ALUOP_W-1:0] OP_LB  = 8'h20;
    localparam logic [ALUOP_W-1:0] OP_LH  = 8'h21;
    localparam logic [ALUOP_W-1:0] OP_LW  = 8'h23;
    localparam logic [ALUOP_W-1:0] OP_LBU = 8'h24;
    localparam logic [ALUOP_W-1:0] OP_LHU = 8'h25;
    localparam logic [ALUOP_W-1:0] OP_SB  = 8'h28;
    localparam logic [ALUOP_W-1:0] OP_SH  = 8'h29;
    localparam logic [ALUOP_W-1:0] OP_SW  = 8'h2b;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Request held stable for the duration of a bus transaction.
    typedef struct packed {
        logic [ALUOP_W-1:0]    op;
        logic [REG_W-1:0]      addr;
        logic [REG_W-1:0]      data;
        logic [REG_ADDR_W-1:0] wd;
        logic                  wreg;
    } lsu_req_t;

    function automatic logic is_load(input logic [ALUOP_W-1:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_store(input logic [ALUOP_W-1:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic is_mem(input logic [ALUOP_W-1:0] op);
        return is_load(op) || is_store(op);
    endfunction

    // Halfword ops need an even address, word ops a word-aligned one.
    function automatic logic is_aligned(input logic [ALUOP_W-1:0] op,
                                        input logic [1:0]         addr_lo);
        case (op)
            OP_LH, OP_LHU, OP_SH: return !addr_lo[0];
            OP_LW, OP_SW:         return addr_lo == 2'b00;
            default:              return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_lane.sv
// Byte-lane steering for the data bus (purely combinational).
//   op, addr_lo : access type and byte offset within the word
//   rs2         : store data            -> sel, wdata (lane-replicated)
//   rdata       : bus read data         -> rdata_ext (extracted, extended)
module mem_lsu_lane
    import mem_lsu_pkg::*;
(
    input  logic [ALUOP_W-1:0] op,
    input  logic [1:0]         addr_lo,
    input  logic [REG_W-1:0]   rs2,
    input  logic [REG_W-1:0]   rdata,
    output logic [3:0]         sel,
    output logic [REG_W-1:0]   wdata,
    output logic [REG_W-1:0]   rdata_ext
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Lane enables and store data replication.
    always_comb begin
        sel   = 4'b0000;
        wdata = '0;
        case (op)
            OP_LB, OP_LBU, OP_SB: sel = 4'b0001 << addr_lo;
            OP_LH, OP_LHU, OP_SH: sel = addr_lo[1] ? 4'b1100 : 4'b0011;
            OP_LW, OP_SW:         sel = 4'b1111;
            default:              sel = 4'b0000;
        endcase
        case (op)
            OP_SB:   wdata = {4{rs2[7:0]}};
            OP_SH:   wdata = {2{rs2[15:0]}};
            OP_SW:   wdata = rs2;
            default: wdata = '0;
        endcase
    end

    // Load extraction with sign/zero extension.
    always_comb begin
        rbyte     = 8'h00;
        rhalf     = rdata[15:0];
        rdata_ext = '0;
        case (addr_lo)
            2'd0:    rbyte = rdata[7:0];
            2'd1:    rbyte = rdata[15:8];
            2'd2:    rbyte = rdata[23:16];
            default: rbyte = rdata[31:24];
        endcase
        if (addr_lo[1]) begin
            rhalf = rdata[31:16];
        end
        case (op)
            OP_LB:   rdata_ext = {{24{rbyte[7]}}, rbyte};
            OP_LBU:  rdata_ext = {24'h000000, rbyte};
            OP_LH:   rdata_ext = {{16{rhalf[15]}}, rhalf};
            OP_LHU:  rdata_ext = {16'h0000, rhalf};
            OP_LW:   rdata_ext = rdata;
            default: rdata_ext = '0;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-access stage of the RV32I pipeline: passes non-memory results
// through with one cycle latency and runs loads/stores over a
// single-outstanding req/ack bus, stalling the pipeline meanwhile.
//   clk, rst        : clock, synchronous active-high reset
//   valid_i..reg2_i : instruction from the ex/mem register
//   wd_o..valid_o   : registered result to the mem/wb register
//   stallreq_o      : combinational stall request (launch and bus cycles)
//   misalign_o      : pulse, misaligned access dropped
//   bus_err_o       : pulse, bus transaction timed out
//   bus_*           : data bus, all zero outside the bus phase
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TO_W    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [REG_W-1:0]      wdata_i,
    input  logic [ALUOP_W-1:0]    aluop_i,
    input  logic [REG_W-1:0]      mem_addr_i,
    input  logic [REG_W-1:0]      reg2_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [REG_W-1:0]      wdata_o,
    output logic                  valid_o,
    output logic                  stallreq_o,
    output logic                  misalign_o,
    output logic                  bus_err_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [REG_W-1:0]      bus_addr_o,
    output logic [3:0]            bus_sel_o,
    output logic [REG_W-1:0]      bus_wdata_o,
    input  logic [REG_W-1:0]      bus_rdata_i,
    input  logic                  bus_ack_i
);

    state_t                state_q, state_d;
    logic [TO_W-1:0]       cnt_q, cnt_d;
    lsu_req_t              req_q, req_d;
    logic [REG_ADDR_W-1:0] wd_d;
    logic                  wreg_d, valid_d, misalign_d, bus_err_d, stall_c;
    logic [REG_W-1:0]      wdata_d;
    logic [3:0]            lane_sel;
    logic [REG_W-1:0]      lane_wdata, lane_rdata;
    logic                  in_bus;

    mem_lsu_lane u_lane (
        .op        (req_q.op),
        .addr_lo   (req_q.addr[1:0]),
        .rs2       (req_q.data),
        .rdata     (bus_rdata_i),
        .sel       (lane_sel),
        .wdata     (lane_wdata),
        .rdata_ext (lane_rdata)
    );

    // State, counter, request latch and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            req_q      <= '0;
            wd_o       <= '0;
            wreg_o     <= 1'b0;
            wdata_o    <= '0;
            valid_o    <= 1'b0;
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            wd_o       <= wd_d;
            wreg_o     <= wreg_d;
            wdata_o    <= wdata_d;
            valid_o    <= valid_d;
            misalign_o <= misalign_d;
            bus_err_o  <= bus_err_d;
        end
    end

    // Next state and next result values; results default to an empty slot.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        wd_d       = '0;
        wreg_d     = 1'b0;
        wdata_d    = '0;
        valid_d    = 1'b0;
        misalign_d = 1'b0;
        bus_err_d  = 1'b0;
        stall_c    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    if (!is_mem(aluop_i)) begin
                        valid_d = 1'b1;
                        wd_d    = wd_i;
                        wreg_d  = wreg_i;
                        wdata_d = wdata_i;
                    end else if (!is_aligned(aluop_i, mem_addr_i[1:0])) begin
                        valid_d    = 1'b1;
                        wd_d       = wd_i;
                        misalign_d = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        req_d   = '{op: aluop_i, addr: mem_addr_i, data: reg2_i,
                                    wd: wd_i, wreg: wreg_i};
                        cnt_d   = '0;
                        state_d = ST_BUS;
                    end
                end
            end
            ST_BUS: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q + TO_W'(1);
                if (bus_ack_i) begin
                    state_d = ST_DONE;
                    valid_d = 1'b1;
                    wd_d    = req_q.wd;
                    if (is_load(req_q.op)) begin
                        wreg_d  = req_q.wreg;
                        wdata_d = lane_rdata;
                    end
                end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                    state_d   = ST_DONE;
                    valid_d   = 1'b1;
                    wd_d      = req_q.wd;
                    bus_err_d = 1'b1;
                end
            end
            ST_DONE: begin
                // Upstream advances at the end of this cycle.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_bus      = (state_q == ST_BUS);
    assign stallreq_o  = stall_c;
    assign bus_req_o   = in_bus;
    assign bus_we_o    = in_bus && is_store(req_q.op);
    assign bus_addr_o  = in_bus ? {req_q.addr[31:2], 2'b00} : '0;
    assign bus_sel_o   = in_bus ? lane_sel : 4'b0000;
    assign bus_wdata_o = in_bus ? lane_wdata : '0;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed vector table, reset-during-bus
// sequence, and randomized ops against a behavioural reference model.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic        clk, rst, valid_i, wreg_i, bus_ack_i;
    logic [4:0]  wd_i;
    logic [31:0] wdata_i, mem_addr_i, reg2_i, bus_rdata_i;
    logic [7:0]  aluop_i;
    logic [4:0]  wd_o;
    logic        wreg_o, valid_o, stallreq_o, misalign_o, bus_err_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] wdata_o, bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_sel_o;

    int checks = 0;
    int errors = 0;

    mem_lsu dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .wdata_i(wdata_i), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i),
        .reg2_i(reg2_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .valid_o(valid_o), .stallreq_o(stallreq_o), .misalign_o(misalign_o),
        .bus_err_o(bus_err_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o),
        .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
        .bus_ack_i(bus_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          got;
        int          req;
        int          stall;
        logic        wreg, mis, err, we, breq_done;
        logic [3:0]  sel;
        logic [31:0] baddr, bwdata, wdata;
        logic [4:0]  wd;
    } res_t;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr, rs2, wdat, rdat;
        logic [4:0]  wd;
        logic        wreg;
        int          ack_at;
        logic [31:0] e_wdata;
        logic [3:0]  e_sel;
        logic [31:0] e_bwdata, e_baddr;
        int          e_req, e_stall;
        logic        e_wreg, e_mis, e_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic bit op_is_store(input logic [7:0] op);
        return op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction

    // Reference model: outcome of one instruction from the ISA rules.
    function automatic res_t model(input logic [7:0] op, input logic [31:0] addr, rs2,
                                   wdat, rdat, input logic [4:0] wd, input logic wreg,
                                   input int ack_at);
        res_t e;
        bit ld, st;
        int sz, sh;
        logic [31:0] v;
        e = '{got: 1'b1, req: 0, stall: 0, wreg: 0, mis: 0, err: 0, we: 0,
              breq_done: 0, sel: 0, baddr: 0, bwdata: 0, wdata: 0, wd: 0};
        ld = op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
        st = op inside {OP_SB, OP_SH, OP_SW};
        if (!ld && !st) begin
            e.wreg = wreg; e.wdata = wdat; e.wd = wd;
            return e;
        end
        sz = (op == OP_LB || op == OP_LBU || op == OP_SB) ? 1 :
             (op == OP_LW || op == OP_SW) ? 4 : 2;
        sh = int'(addr % 4);
        if (sh % sz != 0) begin
            e.mis = 1'b1;
            return e;
        end
        e.err   = (ack_at >= 16);
        e.req   = e.err ? 16 : ack_at + 1;
        e.stall = e.req + 1;
        e.sel   = 4'(((1 << sz) - 1) << sh);
        e.baddr = addr - 32'(sh);
        e.we    = st;
        for (int i = 0; i < 4; i++) e.bwdata[8*i +: 8] = rs2[8*(i % sz) +: 8];
        if (ld && !e.err) begin
            v = rdat >> (8 * sh);
            if (sz == 1) begin
                v = v & 32'hFF;
                if (op == OP_LB && v[7]) v = v | 32'hFFFFFF00;
            end else if (sz == 2) begin
                v = v & 32'hFFFF;
                if (op == OP_LH && v[15]) v = v | 32'hFFFF0000;
            end
            e.wdata = v; e.wreg = wreg; e.wd = wd;
        end
        return e;
    endfunction

    // Issue one instruction, hold it while stalled, ack on the ack_at-th
    // request cycle (0-based, >=16 never). Called at posedge+1.
    task automatic run_op(input logic [7:0] op, input logic [31:0] addr, rs2, wdat,
                          rdat, input logic [4:0] wd, input logic wreg,
                          input int ack_at, output res_t r);
        bit adv;
        r = '{got: 0, req: 0, stall: 0, wreg: 0, mis: 0, err: 0, we: 0,
              breq_done: 0, sel: 0, baddr: 0, bwdata: 0, wdata: 0, wd: 0};
        valid_i = 1'b1; aluop_i = op; mem_addr_i = addr; reg2_i = rs2;
        wdata_i = wdat; wd_i = wd; wreg_i = wreg;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            if (stallreq_o) r.stall++;
            bus_ack_i = 1'b0;
            bus_rdata_i = 32'hDEADBEEF;
            if (bus_req_o) begin
                if (r.req == 0) begin
                    r.sel = bus_sel_o; r.baddr = bus_addr_o;
                    r.bwdata = bus_wdata_o; r.we = bus_we_o;
                end
                if (r.req == ack_at) begin
                    bus_ack_i = 1'b1; bus_rdata_i = rdat;
                end
                r.req++;
            end
            if (valid_o) begin
                r.got = 1'b1; r.wreg = wreg_o; r.mis = misalign_o; r.err = bus_err_o;
                r.wdata = wdata_o; r.wd = wd_o; r.breq_done = bus_req_o;
            end
            adv = !stallreq_o;
            @(posedge clk); #1;
            if (adv) valid_i = 1'b0;
            bus_ack_i = 1'b0;
            if (r.got) break;
        end
        valid_i = 1'b0;
    endtask

    task automatic cmp(input string tag, input res_t a, input res_t e, input bit st);
        chk({tag, " valid_o seen"}, 32'(a.got), 32'(e.got));
        chk({tag, " req cycles"}, 32'(a.req), 32'(e.req));
        chk({tag, " stall cycles"}, 32'(a.stall), 32'(e.stall));
        chk({tag, " wreg_o"}, 32'(a.wreg), 32'(e.wreg));
        chk({tag, " misalign_o"}, 32'(a.mis), 32'(e.mis));
        chk({tag, " bus_err_o"}, 32'(a.err), 32'(e.err));
        chk({tag, " bus_req in result cycle"}, 32'(a.breq_done), 32'd0);
        if (e.wreg) begin
            chk({tag, " wdata_o"}, a.wdata, e.wdata);
            chk({tag, " wd_o"}, 32'(a.wd), 32'(e.wd));
        end
        if (e.req > 0) begin
            chk({tag, " bus_sel_o"}, 32'(a.sel), 32'(e.sel));
            chk({tag, " bus_addr_o"}, a.baddr, e.baddr);
            chk({tag, " bus_we_o"}, 32'(a.we), 32'(st));
            if (st) chk({tag, " bus_wdata_o"}, a.bwdata, e.bwdata);
        end
    endtask

    // After an instruction retires the stage must be quiet and idle.
    task automatic idle_check(input string tag);
        #1;
        chk({tag, " idle valid_o"}, 32'(valid_o), 32'd0);
        chk({tag, " idle bus_req_o"}, 32'(bus_req_o), 32'd0);
        chk({tag, " idle stallreq_o"}, 32'(stallreq_o), 32'd0);
    endtask

    vec_t vecs[14];
    res_t r, e;

    initial begin
        rst = 1'b1; valid_i = 1'b0; wd_i = '0; wreg_i = 1'b0; wdata_i = '0;
        aluop_i = '0; mem_addr_i = '0; reg2_i = '0; bus_rdata_i = '0; bus_ack_i = 1'b0;

        vecs[0]  = '{8'h10, 32'h0, 32'h0, 32'h1234, 32'h0, 5'd5, 1'b1, 0,
                     32'h1234, 4'h0, 32'h0, 32'h0, 0, 0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{OP_SB, 32'h1003, 32'hAB, 32'h0, 32'h0, 5'd7, 1'b1, 0,
                     32'h0, 4'b1000, 32'hABABABAB, 32'h1000, 1, 2, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{OP_LB, 32'h2001, 32'h0, 32'h0, 32'h8000, 5'd3, 1'b1, 0,
                     32'hFFFFFF80, 4'b0010, 32'h0, 32'h2000, 1, 2, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{OP_LBU, 32'h2001, 32'h0, 32'h0, 32'h8000, 5'd3, 1'b1, 0,
                     32'h00000080, 4'b0010, 32'h0, 32'h2000, 1, 2, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{OP_LH, 32'h2002, 32'h0, 32'h0, 32'h80010000, 5'd4, 1'b1, 0,
                     32'hFFFF8001, 4'b1100, 32'h0, 32'h2000, 1, 2, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{OP_LW, 32'h3002, 32'h0, 32'h0, 32'h0, 5'd4, 1'b1, 0,
                     32'h0, 4'h0, 32'h0, 32'h0, 0, 0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{OP_LW, 32'h3000, 32'h0, 32'h0, 32'h0, 5'd6, 1'b1, 99,
                     32'h0, 4'b1111, 32'h0, 32'h3000, 16, 17, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{OP_SH, 32'h0002, 32'h1234ABCD, 32'h0, 32'h0, 5'd8, 1'b1, 2,
                     32'h0, 4'b1100, 32'hABCDABCD, 32'h0, 3, 4, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{OP_LHU, 32'h0000, 32'h0, 32'h0, 32'h1234F00D, 5'd9, 1'b1, 1,
                     32'h0000F00D, 4'b0011, 32'h0, 32'h0, 2, 3, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{OP_SW, 32'h0040, 32'hCAFEBABE, 32'h0, 32'h0, 5'd1, 1'b1, 0,
                     32'h0, 4'b1111, 32'hCAFEBABE, 32'h40, 1, 2, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{OP_LH, 32'h1001, 32'h0, 32'h0, 32'h0, 5'd2, 1'b1, 0,
                     32'h0, 4'h0, 32'h0, 32'h0, 0, 0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{OP_LW, 32'h0010, 32'h0, 32'h0, 32'h89ABCDEF, 5'd31, 1'b1, 15,
                     32'h89ABCDEF, 4'b1111, 32'h0, 32'h10, 16, 17, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{OP_LB, 32'h0007, 32'h0, 32'h0, 32'h7F000000, 5'd11, 1'b1, 0,
                     32'h0000007F, 4'b1000, 32'h0, 32'h4, 1, 2, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{OP_SB, 32'h0005, 32'h12345678, 32'h0, 32'h0, 5'd12, 1'b1, 0,
                     32'h0, 4'b0010, 32'h78787878, 32'h4, 1, 2, 1'b0, 1'b0, 1'b0};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset valid_o", 32'(valid_o), 32'd0);
        chk("reset wreg_o", 32'(wreg_o), 32'd0);
        chk("reset wdata_o", wdata_o, 32'd0);
        chk("reset bus_req_o", 32'(bus_req_o), 32'd0);
        chk("reset stallreq_o", 32'(stallreq_o), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vector table.
        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run_op(vecs[i].op, vecs[i].addr, vecs[i].rs2, vecs[i].wdat, vecs[i].rdat,
                   vecs[i].wd, vecs[i].wreg, vecs[i].ack_at, r);
            e = '{got: 1'b1, req: vecs[i].e_req, stall: vecs[i].e_stall,
                  wreg: vecs[i].e_wreg, mis: vecs[i].e_mis, err: vecs[i].e_err,
                  we: op_is_store(vecs[i].op), breq_done: 1'b0, sel: vecs[i].e_sel,
                  baddr: vecs[i].e_baddr, bwdata: vecs[i].e_bwdata,
                  wdata: vecs[i].e_wdata, wd: vecs[i].wd};
            cmp(tag, r, e, op_is_store(vecs[i].op));
            idle_check(tag);
        end

        // Reset on the second bus cycle, then a late ack.
        valid_i = 1'b1; aluop_i = OP_LW; mem_addr_i = 32'h500; wd_i = 5'd3; wreg_i = 1'b1;
        #1;
        chk("rstbus launch stallreq_o", 32'(stallreq_o), 32'd1);
        @(posedge clk); #1;
        chk("rstbus bus cycle1 bus_req_o", 32'(bus_req_o), 32'd1);
        @(posedge clk); #1;
        chk("rstbus bus cycle2 bus_req_o", 32'(bus_req_o), 32'd1);
        rst = 1'b1; valid_i = 1'b0;
        @(posedge clk); #1;
        chk("rstbus after reset bus_req_o", 32'(bus_req_o), 32'd0);
        chk("rstbus after reset valid_o", 32'(valid_o), 32'd0);
        chk("rstbus after reset stallreq_o", 32'(stallreq_o), 32'd0);
        rst = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'h11111111;
        @(posedge clk); #1;
        bus_ack_i = 1'b0;
        chk("late ack valid_o", 32'(valid_o), 32'd0);
        chk("late ack bus_req_o", 32'(bus_req_o), 32'd0);
        chk("late ack bus_err_o", 32'(bus_err_o), 32'd0);
        @(posedge clk); #1;
        chk("late ack following valid_o", 32'(valid_o), 32'd0);

        // Randomized ops against the reference model.
        for (int n = 0; n < 200; n++) begin
            logic [7:0] op;
            logic [31:0] addr, rs2, wdat, rdat;
            logic [4:0] wd;
            logic wreg;
            int ack_at, k;
            k = int'($urandom_range(0, 9));
            case (k)
                0: op = OP_LB;  1: op = OP_LH;  2: op = OP_LW;  3: op = OP_LBU;
                4: op = OP_LHU; 5: op = OP_SB;  6: op = OP_SH;  7: op = OP_SW;
                default: begin
                    op = 8'($urandom);
                    while (op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
                                      OP_SB, OP_SH, OP_SW}) op = 8'($urandom);
                end
            endcase
            addr = $urandom; rs2 = $urandom; wdat = $urandom; rdat = $urandom;
            wd = 5'($urandom); wreg = 1'($urandom);
            ack_at = int'($urandom_range(0, 20));
            run_op(op, addr, rs2, wdat, rdat, wd, wreg, ack_at, r);
            e = model(op, addr, rs2, wdat, rdat, wd, wreg, ack_at);
            cmp($sformatf("rnd%0d op=%02h", n, op), r, e, op_is_store(op));
            idle_check($sformatf("rnd%0d", n));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                chk($sformatf("rnd%0d bubble valid_o", n), 32'(valid_o), 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
